// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: shared state/stage types and SRAM port widths for the decode sequencer
package decoder_seq_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    typedef enum logic [3:0] {
        IDLE, M3_START, M3_RUN, M2_START, M2_RUN, M1_START, M1_RUN, DONE, ERROR
    } seq_state_t;
    typedef enum logic [1:0] {NONE = 2'd0, M1 = 2'd1, M2 = 2'd2, M3 = 2'd3} stage_t;
endpackage

// File: rtl/stage_timer.sv
// stage_timer: saturating RUN-cycle counter for the active stage plus timeout compare
module stage_timer #(
    parameter int CNT_W = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(24'hFF_FFFF)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] count,
    output logic             expired
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) count <= '0;
        else if (clear) count <= '0;
        else if (run && count != '1) count <= count + 1'b1;
    assign expired = run && TIMEOUT != '0 && count == TIMEOUT;
endmodule

// File: rtl/decoder_sequencer.sv
// decoder_sequencer: runs M3 -> M2 -> M1 in order, owns the SRAM port, times and aborts stages
module decoder_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(24'hFF_FFFF)
) (
    input  logic               CLOCK_50_I,
    input  logic               resetn,
    input  logic               decode_start,
    input  logic               M1_finish,
    input  logic               M2_finish,
    input  logic               M3_finish,
    output logic               M1_start,
    output logic               M2_start,
    output logic               M3_start,
    input  logic [SRAM_AW-1:0] M1_SRAM_address,
    input  logic [SRAM_DW-1:0] M1_SRAM_write_data,
    input  logic               M1_SRAM_we_n,
    input  logic [SRAM_AW-1:0] M2_SRAM_address,
    input  logic [SRAM_DW-1:0] M2_SRAM_write_data,
    input  logic               M2_SRAM_we_n,
    input  logic [SRAM_AW-1:0] M3_SRAM_address,
    input  logic [SRAM_DW-1:0] M3_SRAM_write_data,
    input  logic               M3_SRAM_we_n,
    input  logic [SRAM_AW-1:0] ext_SRAM_address,
    input  logic [SRAM_DW-1:0] ext_SRAM_write_data,
    input  logic               ext_SRAM_we_n,
    output logic [SRAM_AW-1:0] SRAM_address,
    output logic [SRAM_DW-1:0] SRAM_write_data,
    output logic               SRAM_we_n,
    output logic               busy,
    output logic               decode_done,
    output logic               error,
    output logic [1:0]         err_stage,
    output logic [CNT_W-1:0]   M3_cycles,
    output logic [CNT_W-1:0]   M2_cycles,
    output logic [CNT_W-1:0]   M1_cycles
);
    seq_state_t state, state_nxt;
    stage_t stage;
    logic run, finish, expired;
    logic [CNT_W-1:0] count, count_inc;

    always_ff @(posedge CLOCK_50_I or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        stage = state inside {M3_START, M3_RUN} ? M3 :
                state inside {M2_START, M2_RUN} ? M2 :
                state inside {M1_START, M1_RUN} ? M1 : NONE;
        run = state inside {M3_RUN, M2_RUN, M1_RUN};
        finish = run && (stage == M3 ? M3_finish : stage == M2 ? M2_finish : M1_finish);
        state_nxt = state;
        case (state)
            IDLE, ERROR: if (decode_start) state_nxt = M3_START;
            M3_START:    state_nxt = M3_RUN;
            M2_START:    state_nxt = M2_RUN;
            M1_START:    state_nxt = M1_RUN;
            M3_RUN:      state_nxt = finish ? M2_START : expired ? ERROR : M3_RUN;
            M2_RUN:      state_nxt = finish ? M1_START : expired ? ERROR : M2_RUN;
            M1_RUN:      state_nxt = finish ? DONE : expired ? ERROR : M1_RUN;
            default:     state_nxt = IDLE;
        endcase
    end

    stage_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk    (CLOCK_50_I),
        .resetn (resetn),
        .clear  (stage != NONE && !run),
        .run    (run),
        .count  (count),
        .expired(expired)
    );

    // The finish cycle itself counts as a RUN cycle, so latch count+1 (saturated)
    assign count_inc = &count ? count : count + 1'b1;

    always_ff @(posedge CLOCK_50_I or negedge resetn)
        if (!resetn) begin
            M3_cycles <= '0;
            M2_cycles <= '0;
            M1_cycles <= '0;
            error     <= 1'b0;
            err_stage <= 2'd0;
        end else begin
            if (finish && stage == M3) M3_cycles <= count_inc;
            if (finish && stage == M2) M2_cycles <= count_inc;
            if (finish && stage == M1) M1_cycles <= count_inc;
            if (expired && !finish) begin
                error     <= 1'b1;
                err_stage <= stage;
            end else if (state == ERROR && decode_start) begin
                error     <= 1'b0;
                err_stage <= 2'd0;
            end
        end

    assign M3_start    = state == M3_START;
    assign M2_start    = state == M2_START;
    assign M1_start    = state == M1_START;
    assign busy        = !(state inside {IDLE, DONE, ERROR});
    assign decode_done = state == DONE;

    assign SRAM_address    = stage == M3 ? M3_SRAM_address : stage == M2 ? M2_SRAM_address :
                             stage == M1 ? M1_SRAM_address : state == ERROR ? '0 : ext_SRAM_address;
    assign SRAM_write_data = stage == M3 ? M3_SRAM_write_data : stage == M2 ? M2_SRAM_write_data :
                             stage == M1 ? M1_SRAM_write_data : state == ERROR ? '0 : ext_SRAM_write_data;
    assign SRAM_we_n       = stage == M3 ? M3_SRAM_we_n : stage == M2 ? M2_SRAM_we_n :
                             stage == M1 ? M1_SRAM_we_n : state == ERROR ? 1'b1 : ext_SRAM_we_n;
endmodule

// File: tb/tb_decoder_sequencer.sv
// tb_decoder_sequencer: schedule-based scoreboard for the decode sequencer
module tb_decoder_sequencer;
    localparam int TO = 50;

    logic clk = 0, resetn = 0, decode_start = 0;
    logic [3:1] fin = '0;
    logic [17:0] s_addr [4];
    logic [15:0] s_data [4];
    logic s_we [4];
    logic m1_st, m2_st, m3_st, busy, decode_done, error, we_out;
    logic [17:0] addr_out;
    logic [15:0] data_out;
    logic [1:0] err_stage;
    logic [23:0] m3_cyc, m2_cyc, m1_cyc;

    decoder_sequencer #(.TIMEOUT(24'd50)) dut (
        .CLOCK_50_I(clk), .resetn(resetn), .decode_start(decode_start),
        .M1_finish(fin[1]), .M2_finish(fin[2]), .M3_finish(fin[3]),
        .M1_start(m1_st), .M2_start(m2_st), .M3_start(m3_st),
        .M1_SRAM_address(s_addr[1]), .M1_SRAM_write_data(s_data[1]), .M1_SRAM_we_n(s_we[1]),
        .M2_SRAM_address(s_addr[2]), .M2_SRAM_write_data(s_data[2]), .M2_SRAM_we_n(s_we[2]),
        .M3_SRAM_address(s_addr[3]), .M3_SRAM_write_data(s_data[3]), .M3_SRAM_we_n(s_we[3]),
        .ext_SRAM_address(s_addr[0]), .ext_SRAM_write_data(s_data[0]), .ext_SRAM_we_n(s_we[0]),
        .SRAM_address(addr_out), .SRAM_write_data(data_out), .SRAM_we_n(we_out),
        .busy(busy), .decode_done(decode_done), .error(error), .err_stage(err_stage),
        .M3_cycles(m3_cyc), .M2_cycles(m2_cyc), .M1_cycles(m1_cyc)
    );

    always #5 clk = ~clk;

    // Expected event: kind 3/2/1 = Mx_start pulse, 4 = decode_done, 5 = error rise
    typedef struct { int kind; int at; int c3; int c2; int c1; } ev_t;
    ev_t exq[$];
    int owner_m[int];
    int cyc = 0, errors = 0, checks = 0;
    int last [4] = '{default: 0};
    bit err_pending = 0;
    int err_from = 0, err_stg = 0;
    logic prev_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic take_ev(int k);
        ev_t e;
        if (exq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event cycle %0d: got kind %0d expected none", cyc, k);
        end else begin
            e = exq.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.at);
            if (k >= 4) begin
                check("M3_cycles", m3_cyc, e.c3);
                check("M2_cycles", m2_cyc, e.c2);
                check("M1_cycles", m1_cyc, e.c1);
            end
        end
    endtask

    task automatic rst_check();
        check("rst_ctrl", {m3_st, m2_st, m1_st, busy, decode_done, error, err_stage}, 0);
        check("rst_M3_cycles", m3_cyc, 0);
        check("rst_M2_cycles", m2_cyc, 0);
        check("rst_M1_cycles", m1_cyc, 0);
        check("rst_sram", {addr_out, data_out, we_out}, {s_addr[0], s_data[0], s_we[0]});
    endtask

    // Monitor: owner 0 = ext, 1..3 = stage, 4 = ERROR (port parked)
    always @(posedge clk) begin
        int o;
        logic ee;
        #1;
        ee = err_pending && cyc >= err_from;
        o = owner_m.exists(cyc) ? owner_m[cyc] : ee ? 4 : 0;
        if (o == 4) check("sram", {addr_out, data_out, we_out}, {18'd0, 16'd0, 1'b1});
        else check("sram", {addr_out, data_out, we_out}, {s_addr[o], s_data[o], s_we[o]});
        check("status", {busy, error, err_stage}, {o inside {1, 2, 3}, ee, ee ? 2'(err_stg) : 2'd0});
        if (m3_st) take_ev(3);
        if (m2_st) take_ev(2);
        if (m1_st) take_ev(1);
        if (decode_done) take_ev(4);
        if (error && !prev_err) take_ev(5);
        prev_err = error;
    end

    // One decode request; delay 0 means that stage never finishes. rst_at>0 resets during M2 RUN.
    task automatic job(int d3, int d2, int d1, bit spur, int rst_at);
        int t, c, r, stop, err_c, ab;
        int nd [4];
        int s [4];
        int e [4];
        int f [4];
        nd = '{0, d1, d2, d3};
        s = '{default: 1 << 30};
        e = '{default: -1};
        f = '{default: -1};
        t = cyc;
        err_pending = 0;
        c = t + 1;
        ab = 0;
        for (int k = 3; k >= 1; k--) begin
            int rl = nd[k] != 0 ? nd[k] : TO + 1;
            s[k] = c;
            e[k] = c + rl;
            exq.push_back(ev_t'{k, c, 0, 0, 0});
            for (int i = 0; i <= rl; i++) owner_m[c + i] = k;
            c += rl + 1;
            if (nd[k] == 0) begin
                ab = k;
                break;
            end
            f[k] = e[k];
            last[k] = rl;
        end
        err_c = c;
        r = s[2] + rst_at;
        if (rst_at > 0) begin
            for (int i = r + 1; i <= c; i++) owner_m.delete(i);
            while (exq.size() > 0 && exq[$].at > r) void'(exq.pop_back());
            stop = r + 3;
        end else begin
            exq.push_back(ev_t'{ab != 0 ? 5 : 4, c, last[3], last[2], last[1]});
            if (ab != 0) begin
                err_pending = 1;
                err_from = err_c;
                err_stg = ab;
            end
            stop = c + 3 + int'($urandom_range(0, 3));
        end
        for (int cc = t; cc <= stop; cc++) begin
            if (cc > t) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                s_data[k] = 16'($urandom);
                s_we[k] = 1'($urandom);
            end
            decode_start = (cc == t) || (spur && cc == s[2] + 1);
            for (int k = 1; k <= 3; k++)
                fin[k] = (cc == f[k]) || (!(cc > s[k] && cc <= e[k]) && $urandom_range(0, 3) == 0);
            if (spur && cc == s[3]) fin[3] = 1;
            if (spur && cc == s[3] + 2) fin[1] = 1;
            if (rst_at > 0 && cc == r) begin
                resetn = 0;
                #1;
                rst_check();
                last = '{default: 0};
            end
            if (rst_at > 0 && cc == r + 2) resetn = 1;
        end
        decode_start = 0;
        fin = '0;
    endtask

    initial begin
        s_addr[0] = 18'h00001;
        s_addr[1] = 18'h0001A;
        s_addr[2] = 18'h00002;
        s_addr[3] = 18'h00003;
        for (int k = 0; k < 4; k++) begin
            s_data[k] = 16'(k * 16'h1111);
            s_we[k] = 1'b0;
        end
        #1;
        rst_check();
        repeat (3) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        job(10, 20, 30, 0, 0);
        job(12, 5, 7, 1, 0);
        job(10, 0, 5, 0, 0);
        job(3, 4, 5, 0, 0);
        job(6, 0, 9, 0, 7);
        job(10, 20, 30, 0, 0);
        job(1, 1, 1, 0, 0);
        repeat (10) begin
            int d [3];
            for (int i = 0; i < 3; i++) d[i] = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 40));
            job(d[0], d[1], d[2], 0, 0);
        end
        repeat (5) @(negedge clk);
        check("leftover_events", exq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
